// File: rtl/grid_update_ctrl.sv
// Grid cell store for the maze display: four-phase update port from the Arduino,
// full-grid clear sequencer, robot trail tracking and a registered renderer read port.
module grid_update_ctrl #(
  parameter int COLS = 4,
  parameter int ROWS = 5
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       UPD_VALID,
  input  logic [2:0] UPD_X,
  input  logic [2:0] UPD_Y,
  input  logic [1:0] UPD_TYPE,
  output logic       UPD_ACK,
  input  logic       CLEAR_REQ,
  input  logic [2:0] RD_X,
  input  logic [2:0] RD_Y,
  output logic [7:0] RD_COLOR,
  output logic       BUSY,
  output logic       ERR
);

  localparam int NCELL = ROWS * COLS;
  localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_WR_OLD   = 3'd2;
  localparam logic [2:0] ST_WR_NEW   = 3'd3;
  localparam logic [2:0] ST_ACK_WAIT = 3'd4;

  localparam logic [1:0] T_ROBOT = 2'd2;
  localparam logic [7:0] C_VISITED = 8'h1C;

  function automatic logic [7:0] type_color(input logic [1:0] t);
    case (t)
      2'd0:    type_color = 8'h00;
      2'd1:    type_color = 8'h1C;
      2'd2:    type_color = 8'hE0;
      default: type_color = 8'h03;
    endcase
  endfunction

  logic [7:0]       mem [NCELL];
  logic             vld_s1, vld_s2;
  logic [2:0]       state;
  logic [IDX_W-1:0] clr_idx, tgt_idx, rob_idx;
  logic [1:0]       tgt_type;
  logic             rob_vld, clr_pend, ack_r, err_r;

  logic             upd_in_rng, rd_in_rng, clr_last;
  logic [IDX_W-1:0] upd_idx, rd_idx;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [7:0]       mem_wdata;

  assign upd_in_rng = (int'(UPD_X) < COLS) && (int'(UPD_Y) < ROWS);
  assign upd_idx    = IDX_W'(int'(UPD_Y) * COLS + int'(UPD_X));
  assign rd_in_rng  = (int'(RD_X) < COLS) && (int'(RD_Y) < ROWS);
  assign rd_idx     = IDX_W'(int'(RD_Y) * COLS + int'(RD_X));
  assign clr_last   = (clr_idx == IDX_W'(NCELL - 1));

  assign UPD_ACK = ack_r;
  assign ERR     = err_r;
  assign BUSY    = (state == ST_CLEAR) || (state == ST_WR_OLD) || (state == ST_WR_NEW);

  // Single write port; only the clear/write states drive it.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (!RESET) begin
      case (state)
        ST_CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = clr_idx;
        end
        ST_WR_OLD: begin
          mem_we    = 1'b1;
          mem_addr  = rob_idx;
          mem_wdata = C_VISITED;
        end
        ST_WR_NEW: begin
          mem_we    = 1'b1;
          mem_addr  = tgt_idx;
          mem_wdata = type_color(tgt_type);
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Non-blocking read of the array gives read-before-write on a shared cell.
  always_ff @(posedge CLOCK) begin
    if (RESET)          RD_COLOR <= 8'h00;
    else if (rd_in_rng) RD_COLOR <= mem[rd_idx];
    else                RD_COLOR <= 8'h00;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ST_CLEAR;
      clr_idx  <= '0;
      tgt_idx  <= '0;
      tgt_type <= 2'd0;
      rob_idx  <= '0;
      rob_vld  <= 1'b0;
      clr_pend <= 1'b0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      vld_s1   <= 1'b0;
      vld_s2   <= 1'b0;
    end else begin
      vld_s1 <= UPD_VALID;
      vld_s2 <= vld_s1;
      if (CLEAR_REQ) err_r <= 1'b0;
      // Clears requested mid-operation coalesce into one pending flag.
      if (CLEAR_REQ && state != ST_IDLE) clr_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (CLEAR_REQ || clr_pend) begin
            state    <= ST_CLEAR;
            clr_idx  <= '0;
            clr_pend <= 1'b0;
          end else if (vld_s2 && !ack_r) begin
            tgt_idx  <= upd_idx;
            tgt_type <= UPD_TYPE;
            if (!upd_in_rng) begin
              err_r <= 1'b1;
              ack_r <= 1'b1;
              state <= ST_ACK_WAIT;
            end else if (UPD_TYPE == T_ROBOT && rob_vld) begin
              state <= ST_WR_OLD;
            end else begin
              state <= ST_WR_NEW;
            end
          end
        end
        ST_CLEAR: begin
          rob_vld <= 1'b0;
          if (clr_last) state <= ST_IDLE;
          else          clr_idx <= clr_idx + 1'b1;
        end
        ST_WR_OLD: state <= ST_WR_NEW;
        ST_WR_NEW: begin
          if (tgt_type == T_ROBOT) begin
            rob_vld <= 1'b1;
            rob_idx <= tgt_idx;
          end
          ack_r <= 1'b1;
          state <= ST_ACK_WAIT;
        end
        ST_ACK_WAIT: begin
          if (!vld_s2) begin
            ack_r <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_update_ctrl.sv
// Directed + randomized bench for grid_update_ctrl against a grid/robot reference model.
module tb_grid_update_ctrl;
  localparam int COLS = 4;
  localparam int ROWS = 5;
  localparam int N    = ROWS * COLS;
  localparam logic [7:0] CMAP [4] = '{8'h00, 8'h1C, 8'hE0, 8'h03};

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       UPD_VALID = 1'b0;
  logic [2:0] UPD_X = 3'd0, UPD_Y = 3'd0, RD_X = 3'd0, RD_Y = 3'd0;
  logic [1:0] UPD_TYPE = 2'd0;
  logic       CLEAR_REQ = 1'b0;
  logic       UPD_ACK, BUSY, ERR;
  logic [7:0] RD_COLOR;

  grid_update_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .UPD_VALID(UPD_VALID), .UPD_X(UPD_X),
    .UPD_Y(UPD_Y), .UPD_TYPE(UPD_TYPE), .UPD_ACK(UPD_ACK), .CLEAR_REQ(CLEAR_REQ),
    .RD_X(RD_X), .RD_Y(RD_Y), .RD_COLOR(RD_COLOR), .BUSY(BUSY), .ERR(ERR)
  );

  always #20 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [N];
  int   held = -1;
  logic merr = 1'b0;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int x, input int y, input int t);
    int idx;
    if (x >= COLS || y >= ROWS) begin
      merr = 1'b1;
    end else begin
      idx = y * COLS + x;
      if (t == 2) begin
        if (held >= 0) model[held] = 8'h1C;
        model[idx] = 8'hE0;
        held = idx;
      end else begin
        model[idx] = CMAP[t];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) model[i] = 8'h00;
    held = -1;
    merr = 1'b0;
  endtask

  task automatic read_cell(input int x, input int y, output logic [7:0] c);
    RD_X = 3'(x);
    RD_Y = 3'(y);
    tick();
    c = RD_COLOR;
  endtask

  task automatic check_grid(input string tag);
    logic [7:0] c;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        read_cell(x, y, c);
        chk(tag, c, model[y * COLS + x]);
      end
  endtask

  task automatic wait_ack(input logic lvl, output int cnt);
    cnt = 0;
    while (UPD_ACK !== lvl && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (BUSY !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_update(input int x, input int y, input int t);
    int cnt;
    UPD_X = 3'(x);
    UPD_Y = 3'(y);
    UPD_TYPE = 2'(t);
    UPD_VALID = 1'b1;
    wait_ack(1'b1, cnt);
    chk("ack_rise_le6", cnt <= 6, 1);
    chk("busy_in_ack_wait", BUSY, 0);
    model_update(x, y, t);
    chk("err_flag", ERR, merr);
    UPD_VALID = 1'b0;
    wait_ack(1'b0, cnt);
    chk("ack_fall_le3", cnt <= 3, 1);
  endtask

  task automatic do_clear();
    int cnt;
    CLEAR_REQ = 1'b1;
    tick();
    CLEAR_REQ = 1'b0;
    chk("clear_err_low", ERR, 0);
    count_busy(cnt);
    chk("clear_busy_len", cnt, N);
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [7:0] c;
    model_clear();

    // Reset state and post-reset clear length
    repeat (3) tick();
    chk("rst_ack", UPD_ACK, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rdcolor", RD_COLOR, 8'h00);
    RESET = 1'b0;
    count_busy(cnt);
    chk("rst_busy_len", cnt, N);
    check_grid("rst_grid");

    // Visited cell
    do_update(2, 3, 1);
    read_cell(2, 3, c);
    chk("visited_2_3", c, 8'h1C);

    // Robot move leaves a visited trail
    do_update(0, 0, 2);
    do_update(1, 0, 2);
    read_cell(0, 0, c);
    chk("robot_trail_0_0", c, 8'h1C);
    read_cell(1, 0, c);
    chk("robot_now_1_0", c, 8'hE0);

    // Out-of-range update then clear
    do_update(5, 0, 1);
    chk("oor_err_set", ERR, 1);
    check_grid("oor_grid");
    do_clear();
    check_grid("clear_grid");

    // Randomized updates, including out-of-range coordinates
    for (int i = 0; i < 14; i++)
      do_update(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    check_grid("rand_grid");
    read_cell(5, 0, c);
    chk("rd_oor_x", c, 8'h00);
    read_cell(0, 7, c);
    chk("rd_oor_y", c, 8'h00);

    // Read-before-write on (1,1)
    do_update(1, 1, 1);
    RD_X = 3'd1; RD_Y = 3'd1;
    UPD_X = 3'd1; UPD_Y = 3'd1; UPD_TYPE = 2'd3;
    UPD_VALID = 1'b1;
    wait_busy(cnt);
    chk("rbw_busy_seen", cnt < 20, 1);
    tick();
    chk("rbw_old", RD_COLOR, model[5]);
    tick();
    chk("rbw_new", RD_COLOR, 8'h03);
    model_update(1, 1, 3);
    wait_ack(1'b1, cnt);
    chk("rbw_ack", UPD_ACK, 1);
    UPD_VALID = 1'b0;
    wait_ack(1'b0, cnt);
    chk("rbw_ack_fall", UPD_ACK, 0);

    // Clear requested during WR_NEW and again during ACK_WAIT: one deferred clear
    UPD_X = 3'd3; UPD_Y = 3'd4; UPD_TYPE = 2'd3;
    UPD_VALID = 1'b1;
    wait_busy(cnt);
    chk("defer_busy_seen", cnt < 20, 1);
    CLEAR_REQ = 1'b1;
    tick();
    CLEAR_REQ = 1'b0;
    chk("defer_ack", UPD_ACK, 1);
    model_update(3, 4, 3);
    read_cell(3, 4, c);
    chk("defer_written", c, 8'h03);
    CLEAR_REQ = 1'b1;
    tick();
    CLEAR_REQ = 1'b0;
    tick();
    chk("defer_ack_held", UPD_ACK, 1);
    chk("defer_not_busy", BUSY, 0);
    UPD_VALID = 1'b0;
    wait_ack(1'b0, cnt);
    chk("defer_ack_fall", cnt <= 3, 1);
    wait_busy(cnt);
    chk("defer_clear_start", cnt < 20, 1);
    count_busy(cnt);
    chk("defer_clear_len", cnt, N);
    tick();
    tick();
    chk("defer_coalesced", BUSY, 0);
    model_clear();
    check_grid("defer_grid");
    chk("defer_err", ERR, 0);

    // Reset during a robot update: aborted, then serviced after the clear
    do_update(2, 2, 2);
    UPD_X = 3'd3; UPD_Y = 3'd3; UPD_TYPE = 2'd2;
    UPD_VALID = 1'b1;
    wait_busy(cnt);
    RESET = 1'b1;
    tick();
    chk("midrst_ack", UPD_ACK, 0);
    tick();
    RESET = 1'b0;
    model_clear();
    count_busy(cnt);
    chk("midrst_busy_len", cnt, N);
    wait_ack(1'b1, cnt);
    chk("midrst_serviced", cnt <= 6, 1);
    model_update(3, 3, 2);
    UPD_VALID = 1'b0;
    wait_ack(1'b0, cnt);
    chk("midrst_ack_fall", cnt <= 3, 1);
    check_grid("midrst_grid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
